unibus_master: RTL

//  Unibus bus-master (initiator) engine: turns single-word requests from a local

---
 rtl/unibus_master.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/unibus_master.sv
// Unibus bus-master engine: runs one DATI/DATO/DATOB cycle per accepted request,
// sequencing deskew, MSYN/SSYN handshake, takedown and hold, with SSYN timeout.
module unibus_master #(
    parameter int DESKEW  = 4,
    parameter int HOLD    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        byte_op,
    input  logic [17:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic [17:0] bus_addr_out,
    output logic [1:0]  bus_c_out,
    output logic [15:0] bus_d_out,
    output logic        bus_msyn_out,
    input  logic        bus_ssyn,
    input  logic [15:0] bus_d
);

    localparam int CNT_MAX = (DESKEW > HOLD) ? DESKEW : HOLD;
    localparam int CW      = $clog2(CNT_MAX + 1) + 1;
    localparam int TW      = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] DESKEW_C    = CW'(DESKEW);
    localparam logic [CW-1:0] HOLD_LAST_C = CW'(HOLD - 1);
    localparam logic [TW-1:0] TMAX_C      = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_MSYN     = 3'd2,
        ST_TAKEDOWN = 3'd3,
        ST_HOLD     = 3'd4
    } state_t;

    // C1,C0 bus encoding of the transfer type
    function automatic logic [1:0] ctl_code(input logic w, input logic b);
        if (w) begin
            ctl_code = {1'b1, b};
        end else begin
            ctl_code = 2'b00;
        end
    endfunction

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [TW-1:0] tmr_r, tmr_s;
    logic          we_r, we_s;
    logic          byte_r, byte_s;
    logic [17:0]   addr_r, addr_s;
    logic [15:0]   wdata_r, wdata_s;
    logic          err_acc_r, err_acc_s;
    logic          busy_r, busy_s;
    logic          ack_r, ack_s;
    logic          err_r, err_s;
    logic [15:0]   rdata_r, rdata_s;
    logic [17:0]   baddr_r, baddr_s;
    logic [1:0]    bc_r, bc_s;
    logic [15:0]   bd_r, bd_s;
    logic          msyn_r, msyn_s;

    // Next-state and next-output computation for the whole cycle sequencer
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        tmr_s     = tmr_r;
        we_s      = we_r;
        byte_s    = byte_r;
        addr_s    = addr_r;
        wdata_s   = wdata_r;
        err_acc_s = err_acc_r;
        busy_s    = busy_r;
        ack_s     = 1'b0;
        err_s     = 1'b0;
        rdata_s   = rdata_r;
        baddr_s   = baddr_r;
        bc_s      = bc_r;
        bd_s      = bd_r;
        msyn_s    = msyn_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    we_s    = we;
                    byte_s  = byte_op;
                    addr_s  = addr;
                    wdata_s = wdata;
                    busy_s  = 1'b1;
                    cnt_s   = '0;
                    state_s = ST_SETUP;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            ST_SETUP: begin
                baddr_s = addr_r;
                bc_s    = ctl_code(we_r, byte_r);
                bd_s    = we_r ? wdata_r : 16'd0;
                // A stuck SSYN from the previous responder stalls here without timeout
                if ((cnt_r >= DESKEW_C) && !bus_ssyn) begin
                    msyn_s  = 1'b1;
                    tmr_s   = '0;
                    state_s = ST_MSYN;
                end else if (cnt_r < DESKEW_C) begin
                    cnt_s   = cnt_r + 1'b1;
                end else begin
                    cnt_s   = cnt_r;
                end
            end
            ST_MSYN: begin
                if (bus_ssyn) begin
                    if (!we_r) begin
                        rdata_s = bus_d;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    err_acc_s = 1'b0;
                    msyn_s    = 1'b0;
                    tmr_s     = '0;
                    state_s   = ST_TAKEDOWN;
                end else if (tmr_r >= TMAX_C) begin
                    err_acc_s = 1'b1;
                    msyn_s    = 1'b0;
                    tmr_s     = '0;
                    state_s   = ST_TAKEDOWN;
                end else begin
                    tmr_s     = tmr_r + 1'b1;
                end
            end
            ST_TAKEDOWN: begin
                if (!bus_ssyn) begin
                    cnt_s   = '0;
                    state_s = ST_HOLD;
                end else if (tmr_r >= TMAX_C) begin
                    err_acc_s = 1'b1;
                    cnt_s     = '0;
                    state_s   = ST_HOLD;
                end else begin
                    tmr_s   = tmr_r + 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_r >= HOLD_LAST_C) begin
                    baddr_s = 18'd0;
                    bc_s    = 2'b00;
                    bd_s    = 16'd0;
                    ack_s   = 1'b1;
                    err_s   = err_acc_r;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s   = cnt_r + 1'b1;
                end
            end
            default: begin
                baddr_s = 18'd0;
                bc_s    = 2'b00;
                bd_s    = 16'd0;
                msyn_s  = 1'b0;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update; reset releases the bus asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            tmr_r     <= '0;
            we_r      <= 1'b0;
            byte_r    <= 1'b0;
            addr_r    <= 18'd0;
            wdata_r   <= 16'd0;
            err_acc_r <= 1'b0;
            busy_r    <= 1'b0;
            ack_r     <= 1'b0;
            err_r     <= 1'b0;
            rdata_r   <= 16'd0;
            baddr_r   <= 18'd0;
            bc_r      <= 2'b00;
            bd_r      <= 16'd0;
            msyn_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            tmr_r     <= tmr_s;
            we_r      <= we_s;
            byte_r    <= byte_s;
            addr_r    <= addr_s;
            wdata_r   <= wdata_s;
            err_acc_r <= err_acc_s;
            busy_r    <= busy_s;
            ack_r     <= ack_s;
            err_r     <= err_s;
            rdata_r   <= rdata_s;
            baddr_r   <= baddr_s;
            bc_r      <= bc_s;
            bd_r      <= bd_s;
            msyn_r    <= msyn_s;
        end
    end

    assign busy         = busy_r;
    assign ack          = ack_r;
    assign err          = err_r;
    assign rdata        = rdata_r;
    assign bus_addr_out = baddr_r;
    assign bus_c_out    = bc_r;
    assign bus_d_out    = bd_r;
    assign bus_msyn_out = msyn_r;

endmodule
